// File: rtl/vga_pkg.sv
// vga_pkg: shared constants for the 640x480@60 Hz raster timing block.
//   - default horizontal/vertical timing values and their totals
//   - colour and coordinate widths used on the block's ports
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 800

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 525

    localparam int RGB_W    = 12;
    localparam int COORD_W  = 11;

endpackage

// File: rtl/vga_timing_gen_sync_delay.sv
// sync_delay: WIDTH x DEPTH shift register with a synchronous reset value.
//   clk     - clock
//   reset   - synchronous active-high; every stage loads rst_val
//   rst_val - value loaded into all stages on reset
//   d       - input word
//   q       - d delayed by DEPTH clocks (DEPTH >= 1)
module sync_delay #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [DEPTH-1:0][WIDTH-1:0] stage;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                stage[i] <= rst_val;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++)
                stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator.
//   clk, reset   - pixel clock, synchronous active-high reset
//   x, y         - raster counters handed to the colour stage
//   de           - x/y inside the visible area (aligned with x/y)
//   frame_start  - high for the single cycle where x==0 && y==0
//   rgb_in       - colour for x/y, returned PIPE_DLY clocks later
//   vga_hs/vs    - registered syncs aligned with vga_rgb
//   vga_rgb      - registered colour, forced to 0 outside the visible area
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP,
    parameter bit SYNC_POL = 1'b0,
    parameter int PIPE_DLY = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               de,
    output logic               frame_start,
    input  logic [RGB_W-1:0]   rgb_in,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic [RGB_W-1:0]   vga_rgb
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOT - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOT - 1);
    localparam logic [COORD_W-1:0] H_VIS  = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_VIS  = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_BEG = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_BEG = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [COORD_W-1:0] h, v;
    logic               hs_raw, vs_raw;
    logic               hs_dly, vs_dly, de_dly;

    // Raster counters: v advances only when h wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + 1'b1;
        end else begin
            h <= h + 1'b1;
        end
    end

    assign x           = h;
    assign y           = v;
    assign de          = (h < H_VIS) && (v < V_VIS);
    assign frame_start = (h == '0) && (v == '0);

    assign hs_raw = (h >= HS_BEG && h < HS_END) ? SYNC_POL : ~SYNC_POL;
    assign vs_raw = (v >= VS_BEG && v < VS_END) ? SYNC_POL : ~SYNC_POL;

    // Match the colour stage latency so syncs/de land with rgb_in.
    sync_delay #(
        .WIDTH (3),
        .DEPTH (PIPE_DLY)
    ) u_sync_delay (
        .clk     (clk),
        .reset   (reset),
        .rst_val ({~SYNC_POL, ~SYNC_POL, 1'b0}),
        .d       ({hs_raw, vs_raw, de}),
        .q       ({hs_dly, vs_dly, de_dly})
    );

    // Pin register; the mux keeps undriven/X colour from leaking in blanking.
    always_ff @(posedge clk) begin
        if (reset) begin
            vga_hs  <= ~SYNC_POL;
            vga_vs  <= ~SYNC_POL;
            vga_rgb <= '0;
        end else begin
            vga_hs  <= hs_dly;
            vga_vs  <= vs_dly;
            vga_rgb <= de_dly ? rgb_in : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;
    import vga_pkg::*;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        de;
        logic        fs;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } exp_t;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic reset;
    int   mode = 0;          // 0: coord pattern, 1: constant FFF, 2: FFF active / X blank
    int   seg_mode = 0;
    int   t = 0;             // clocks since the last reset edge
    bit   trk = 1'b0;
    int   checks = 0;
    int   passes = 0;

    // default 640x480 instance
    logic [10:0] a_x, a_y;
    logic        a_de, a_fs, a_hs, a_vs;
    logic [11:0] a_rgb_in, a_rgb;
    // small-frame instance, positive syncs, 3-deep colour stage
    logic [10:0] b_x, b_y;
    logic        b_de, b_fs, b_hs, b_vs;
    logic [11:0] b_rgb_in, b_rgb;

    vga_timing_gen dut_a (
        .clk(clk), .reset(reset), .x(a_x), .y(a_y), .de(a_de), .frame_start(a_fs),
        .rgb_in(a_rgb_in), .vga_hs(a_hs), .vga_vs(a_vs), .vga_rgb(a_rgb)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3),
        .SYNC_POL(1'b1), .PIPE_DLY(3)
    ) dut_b (
        .clk(clk), .reset(reset), .x(b_x), .y(b_y), .de(b_de), .frame_start(b_fs),
        .rgb_in(b_rgb_in), .vga_hs(b_hs), .vga_vs(b_vs), .vga_rgb(b_rgb)
    );

    // colour stage models
    function automatic logic [11:0] stage_col(input logic [10:0] cx, input logic [10:0] cy,
                                              input logic cde, input int m);
        if (m == 0) return {cx[3:0], cy[3:0], 4'hA};
        if (m == 1) return 12'hFFF;
        return cde ? 12'hFFF : 12'hxxx;
    endfunction

    logic [11:0] a_cp [0:1];
    logic [11:0] b_cp [0:2];
    always @(posedge clk) begin
        a_cp[0] <= stage_col(a_x, a_y, a_de, mode);
        a_cp[1] <= a_cp[0];
        b_cp[0] <= stage_col(b_x, b_y, b_de, mode);
        b_cp[1] <= b_cp[0];
        b_cp[2] <= b_cp[1];
    end
    assign a_rgb_in = a_cp[1];
    assign b_rgb_in = b_cp[2];

    always @(posedge clk) begin
        if (reset) begin
            t        <= 0;
            trk      <= 1'b1;
            seg_mode <= mode;
        end else begin
            t <= t + 1;
        end
    end

    // Reference: what each output must be t clocks after reset.
    function automatic logic [11:0] ref_col(input int h, input int v, input int m);
        logic [11:0] hv;
        logic [11:0] vv;
        hv = 12'(h);
        vv = 12'(v);
        return (m == 0) ? {hv[3:0], vv[3:0], 4'hA} : 12'hFFF;
    endfunction

    function automatic exp_t model(input int tt, input int ha, input int hf, input int hsw,
                                   input int hb, input int va, input int vf, input int vsw,
                                   input int vb, input int d, input bit pol, input int m);
        exp_t e;
        int ht, vt, h, v, u;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        h = tt % ht;
        v = (tt / ht) % vt;
        e.x  = 11'(h);
        e.y  = 11'(v);
        e.de = (h < ha) && (v < va);
        e.fs = (h == 0) && (v == 0);
        if (tt < d + 1) begin
            e.hs  = ~pol;
            e.vs  = ~pol;
            e.rgb = 12'h000;
        end else begin
            u = tt - d - 1;
            h = u % ht;
            v = (u / ht) % vt;
            e.hs  = (h >= ha + hf && h < ha + hf + hsw) ? pol : ~pol;
            e.vs  = (v >= va + vf && v < va + vf + vsw) ? pol : ~pol;
            e.rgb = (h < ha && v < va) ? ref_col(h, v, m) : 12'h000;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s at t=%0d: got %h want %h", name, t, act, exp);
        else
            passes++;
    endtask

    // per-cycle comparison against the reference
    always @(negedge clk) begin
        if (trk) begin
            exp_t ea, eb, aa, ab;
            ea = model(t, H_ACTIVE, H_FP, H_SYNC, H_BP, V_ACTIVE, V_FP, V_SYNC, V_BP,
                       2, 1'b0, seg_mode);
            eb = model(t, 16, 2, 4, 3, 8, 2, 2, 3, 3, 1'b1, seg_mode);
            aa = {a_x, a_y, a_de, a_fs, a_hs, a_vs, a_rgb};
            ab = {b_x, b_y, b_de, b_fs, b_hs, b_vs, b_rgb};
            chk("cycle_a", 64'(aa), 64'(ea));
            chk("cycle_b", 64'(ab), 64'(eb));
        end
    end

    // window counters (pin-side), cleared at each reset
    int a_hsl = 0, b_act = 0, b_vsc = 0, b_fsp = 0, b_per = 0;
    always @(negedge clk) begin
        if (trk) begin
            if (t == 0) begin
                a_hsl <= 0; b_act <= 0; b_vsc <= 0; b_fsp <= 0; b_per <= 0;
            end else begin
                if (t >= 3 && t < 803 && !a_hs) a_hsl <= a_hsl + 1;
                if (t >= 4 && t < 379) begin
                    if (b_rgb != 12'h000) b_act <= b_act + 1;
                    if (b_vs) b_vsc <= b_vsc + 1;
                end
                if (b_fs) begin
                    b_per <= t - b_fsp;
                    b_fsp <= t;
                end
            end
        end
    end

    task automatic wait_t(input int tgt);
        int n;
        n = 0;
        while (t != tgt) begin
            @(negedge clk);
            n++;
            if (n > 5000) begin
                chk("timeout", 64'(t), 64'(tgt));
                return;
            end
        end
    endtask

    task automatic small_frame_checks();
        wait_t(380);
        chk("b_active_cnt", 64'(b_act), 64'd128);
        chk("b_vs_cnt", 64'(b_vsc), 64'd50);
        chk("b_frame_period", 64'(b_per), 64'd375);
    endtask

    initial begin
        reset = 1'b1;
        mode  = 0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_a_pins", 64'({a_hs, a_vs, a_rgb}), 64'({1'b1, 1'b1, 12'h000}));
        chk("rst_b_pins", 64'({b_hs, b_vs, b_rgb}), 64'({1'b0, 1'b0, 12'h000}));
        reset = 1'b0;
        chk("rel_xy", 64'({a_x, a_y}), 64'd0);
        chk("rel_fs_de", 64'({a_fs, a_de}), 64'b11);
        @(negedge clk);
        chk("x_one", 64'(a_x), 64'd1);
        chk("fs_low", 64'(a_fs), 64'd0);
        wait_t(2);   chk("rgb_blank_t2", 64'(a_rgb), 64'h000);
        wait_t(3);   chk("rgb_0_0", 64'(a_rgb), 64'h00A);
        wait_t(4);   chk("rgb_1_0", 64'(a_rgb), 64'h10A);
        wait_t(18);  chk("rgb_15_0", 64'(a_rgb), 64'hF0A);
        wait_t(19);  chk("rgb_16_0", 64'(a_rgb), 64'h00A);
        small_frame_checks();
        wait_t(642); chk("rgb_639_0", 64'(a_rgb), 64'hF0A);
        wait_t(643); chk("rgb_640_blank", 64'(a_rgb), 64'h000);
        wait_t(658); chk("hs_before", 64'(a_hs), 64'd1);
        wait_t(659); chk("hs_fall", 64'(a_hs), 64'd0);
        wait_t(754); chk("hs_last", 64'(a_hs), 64'd0);
        wait_t(755); chk("hs_rise", 64'(a_hs), 64'd1);
        wait_t(799); chk("xy_799_0", 64'({a_x, a_y}), 64'({11'd799, 11'd0}));
        wait_t(800); chk("xy_0_1", 64'({a_x, a_y}), 64'({11'd0, 11'd1}));
        wait_t(803); chk("rgb_0_1", 64'(a_rgb), 64'h01A);
        wait_t(804); chk("rgb_1_1", 64'(a_rgb), 64'h11A);
        wait_t(810); chk("hs_low_len", 64'(a_hsl), 64'd96);
        wait_t(1100);
        chk("xy_300_1", 64'({a_x, a_y}), 64'({11'd300, 11'd1}));

        // mid-frame reset, X colour during blanking
        reset = 1'b1;
        mode  = 2;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_xy", 64'({a_x, a_y, a_fs}), 64'({11'd0, 11'd0, 1'b1}));
        chk("mid_rst_pins", 64'({a_hs, a_vs, a_rgb}), 64'({1'b1, 1'b1, 12'h000}));
        wait_t(2); chk("mid_rst_blank", 64'({a_hs, a_rgb}), 64'({1'b1, 12'h000}));
        wait_t(3); chk("mid_rst_first", 64'(a_rgb), 64'hFFF);
        small_frame_checks();
        wait_t(900);

        // constant full-white colour
        reset = 1'b1;
        mode  = 1;
        @(negedge clk);
        reset = 1'b0;
        small_frame_checks();
        wait_t(643); chk("white_blank", 64'(a_rgb), 64'h000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
